// File: rtl/noc_ctr_pkg.sv
// noc_ctr_pkg: shared opcode encoding and default width for the shared counter
package noc_ctr_pkg;
   typedef enum logic [1:0] {CTR_READ, CTR_INC, CTR_DEC, CTR_LOAD} ctr_op_t;
   localparam int CTR_W = 8;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search starting at ptr, wrapping at N-1
module rr_arbiter #(
   parameter int N = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] idx
);
   int j;
   // scanning from the farthest offset down leaves the closest requester as winner
   always_comb begin
      gnt = '0;
      idx = '0;
      j = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         if (req[j]) begin
            gnt = '0;
            gnt[j] = 1'b1;
            idx = IDW'(j);
         end
      end
   end
endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter: saturating up/down counter shared by N round-robin requesters
module counter_arbiter
   import noc_ctr_pkg::*;
#(
   parameter int N = 4,
   parameter int W = CTR_W,
   localparam int IDW = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic [2*N-1:0]   op,
   input  logic [W*N-1:0]   wdata,
   output logic [N-1:0]     gnt,
   output logic             rvalid,
   output logic [IDW-1:0]   rid,
   output logic [W-1:0]     rdata,
   output logic [W-1:0]     count,
   output logic             ovf,
   output logic             udf
);
   logic [N-1:0]   arb_gnt;
   logic [IDW-1:0] idx, ptr;
   logic [W:0]     inc, dec;
   logic [W-1:0]   nxt, wd;
   logic           any, is_inc, is_dec, is_load;
   ctr_op_t        op_i;
   rr_arbiter #(.N(N)) u_arb (.req(req), .ptr(ptr), .gnt(arb_gnt), .idx(idx));
   assign gnt     = rst ? '0 : arb_gnt;
   assign any     = |gnt;
   assign op_i    = ctr_op_t'(op[2*idx +: 2]);
   assign wd      = wdata[W*idx +: W];
   assign is_inc  = op_i == CTR_INC;
   assign is_dec  = op_i == CTR_DEC;
   assign is_load = op_i == CTR_LOAD;
   // the extra top bit flags saturation in either direction, so the count never wraps
   assign inc     = {1'b0, count} + (W+1)'(1);
   assign dec     = {1'b0, count} - (W+1)'(1);
   assign nxt     = is_load ? wd :
                    is_inc && !inc[W] ? inc[W-1:0] :
                    is_dec && !dec[W] ? dec[W-1:0] : count;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         ptr    <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
         rvalid <= 1'b0;
         rid    <= '0;
         rdata  <= '0;
      end else begin
         rvalid <= any;
         if (any) begin
            count <= nxt;
            ptr   <= idx == IDW'(N - 1) ? '0 : idx + IDW'(1);
            rid   <= idx;
            rdata <= nxt;
            ovf   <= is_load ? 1'b0 : ovf | (is_inc & inc[W]);
            udf   <= is_load ? 1'b0 : udf | (is_dec & dec[W]);
         end
      end
   end
endmodule
